// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared bus constants, load-tag and sequencer state types
package gb_bus_pkg;

    localparam logic [15:0] REG_ADDR_DMA = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_START   = 16'hFF80;
    localparam logic [15:0] HRAM_END     = 16'hFFFE;
    localparam int          DMA_LEN      = 160;

    // Source of c_outdata for a CPU load accepted two cycles earlier.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_BUS,
        TAG_REG,
        TAG_BLOCKED
    } load_tag_e;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } seq_state_e;

    localparam logic [7:0] BLOCKED_DATA = 8'hFF;

endpackage

// File: rtl/oam_dma_seq.sv
// rtl/oam_dma_seq.sv - OAM DMA phase/index counters and address generation
module oam_dma_seq
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] DST_START = OAM_BASE,
    parameter int          LEN       = DMA_LEN
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        trigger,
    input  logic [7:0]  trig_page,
    output logic        dma_active,
    output logic        cpu_slot,
    output logic        dma_load,
    output logic        dma_store,
    output logic [7:0]  page,
    output logic [15:0] src_addr,
    output logic [15:0] dst_addr
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    seq_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  phase_q, phase_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= SEQ_IDLE;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    // A trigger always wins, so a store to the page register mid-transfer restarts cleanly.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (trigger) begin
            state_d = SEQ_RUN;
            page_d  = trig_page;
            idx_d   = 8'h00;
            phase_d = 2'd0;
        end else if (state_q == SEQ_RUN) begin
            phase_d = phase_q + 2'd1;
            if (phase_q == 2'd3) begin
                if (idx_q == LAST_IDX) begin
                    state_d = SEQ_IDLE;
                    idx_d   = 8'h00;
                end else begin
                    idx_d = idx_q + 8'h01;
                end
            end
        end
    end

    assign dma_active = (state_q == SEQ_RUN);
    assign cpu_slot   = dma_active && phase_q[0];
    assign dma_load   = dma_active && (phase_q == 2'd0);
    assign dma_store  = dma_active && (phase_q == 2'd2);
    assign page       = page_q;
    assign src_addr   = {page_q, idx_q};
    assign dst_addr   = DST_START + {8'h00, idx_q};

endmodule

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - CPU/OAM-DMA bus arbiter with load-latency tagging
module oam_dma_arbiter
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] REG_ADDR   = REG_ADDR_DMA,
    parameter logic [15:0] DST_START  = OAM_BASE,
    parameter int          LEN        = DMA_LEN,
    parameter logic [15:0] HRAM_LO    = HRAM_START,
    parameter logic [15:0] HRAM_HI    = HRAM_END
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] c_address,
    input  logic [7:0]  c_indata,
    output logic [7:0]  c_outdata,
    input  logic        c_load,
    input  logic        c_store,
    output logic        c_ready,
    output logic [15:0] m_address,
    output logic [7:0]  m_indata,
    input  logic [7:0]  m_outdata,
    output logic        m_load,
    output logic        m_store,
    output logic        dma_active
);

    logic        trigger;
    logic        cpu_slot;
    logic        dma_load;
    logic        dma_store;
    logic [7:0]  page;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic        cpu_load;
    logic        is_reg;
    logic        in_hram;
    load_tag_e   tag_now, tag_d1, tag_d2;

    oam_dma_seq #(
        .DST_START (DST_START),
        .LEN       (LEN)
    ) u_seq (
        .clock      (clock),
        .resetn     (resetn),
        .trigger    (trigger),
        .trig_page  (c_indata),
        .dma_active (dma_active),
        .cpu_slot   (cpu_slot),
        .dma_load   (dma_load),
        .dma_store  (dma_store),
        .page       (page),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr)
    );

    // A simultaneous store masks the load entirely.
    assign cpu_load = c_load && !c_store;
    assign is_reg   = (c_address == REG_ADDR);
    assign in_hram  = (c_address >= HRAM_LO) && (c_address <= HRAM_HI);
    assign trigger  = c_store && is_reg;

    always_comb begin
        m_address = c_address;
        m_indata  = c_indata;
        m_load    = 1'b0;
        m_store   = 1'b0;
        c_ready   = 1'b1;
        tag_now   = TAG_NONE;
        if (!dma_active) begin
            if (is_reg) begin
                if (cpu_load) tag_now = TAG_REG;
            end else begin
                m_load  = cpu_load;
                m_store = c_store;
                if (cpu_load) tag_now = TAG_BUS;
            end
        end else if (dma_load) begin
            m_address = src_addr;
            m_load    = 1'b1;
        end else if (dma_store) begin
            m_address = dst_addr;
            m_indata  = m_outdata;
            m_store   = 1'b1;
        end
        // CPU side while the engine owns the bus; odd phases are the CPU's HRAM slots.
        if (dma_active && !trigger) begin
            if (in_hram) begin
                if (cpu_slot) begin
                    m_load  = cpu_load;
                    m_store = c_store;
                    if (cpu_load) tag_now = TAG_BUS;
                end else if (c_load || c_store) begin
                    c_ready = 1'b0;
                end
            end else if (cpu_load) begin
                tag_now = TAG_BLOCKED;
            end
        end
        if (!resetn) begin
            m_load  = 1'b0;
            m_store = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_d1 <= TAG_NONE;
            tag_d2 <= TAG_NONE;
        end else begin
            tag_d1 <= tag_now;
            tag_d2 <= tag_d1;
        end
    end

    always_comb begin
        c_outdata = 8'h00;
        case (tag_d2)
            TAG_BUS:     c_outdata = m_outdata;
            TAG_REG:     c_outdata = page;
            TAG_BLOCKED: c_outdata = BLOCKED_DATA;
            default:     c_outdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - directed self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] c_address;
    logic [7:0]  c_indata;
    logic [7:0]  c_outdata;
    logic        c_load;
    logic        c_store;
    logic        c_ready;
    logic [15:0] m_address;
    logic [7:0]  m_indata;
    logic [7:0]  m_outdata;
    logic        m_load;
    logic        m_store;
    logic        dma_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;
    int bad;

    logic [7:0] mem [0:65535];
    logic [7:0] rd_d1, rd_d2;

    oam_dma_arbiter dut (
        .clock      (clock),
        .resetn     (resetn),
        .c_address  (c_address),
        .c_indata   (c_indata),
        .c_outdata  (c_outdata),
        .c_load     (c_load),
        .c_store    (c_store),
        .c_ready    (c_ready),
        .m_address  (m_address),
        .m_indata   (m_indata),
        .m_outdata  (m_outdata),
        .m_load     (m_load),
        .m_store    (m_store),
        .dma_active (dma_active)
    );

    always #5 clock = ~clock;

    // Bus fabric model: stores land at the edge, load data appears two cycles later.
    always @(posedge clock) begin
        if (m_store) mem[m_address] <= m_indata;
        rd_d1 <= m_load ? mem[m_address] : 8'h00;
        rd_d2 <= rd_d1;
    end
    assign m_outdata = rd_d2;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle_cpu();
        c_load  = 1'b0;
        c_store = 1'b0;
        c_address = 16'h0000;
        c_indata  = 8'h00;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
        mem[16'hC000] = 8'h5A;
        rd_d1 = 8'h00;
        rd_d2 = 8'h00;
        resetn = 1'b0;
        idle_cpu();
        #2;
        chk("rst_c_outdata", c_outdata, 8'h00);
        chk("rst_m_load", m_load, 1'b0);
        chk("rst_m_store", m_store, 1'b0);
        chk("rst_c_ready", c_ready, 1'b1);
        chk("rst_dma_active", dma_active, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Idle pass-through load
        c_load = 1'b1; c_address = 16'hC000;
        #1;
        chk("idle_m_load", m_load, 1'b1);
        chk("idle_m_address", m_address, 16'hC000);
        chk("idle_c_ready", c_ready, 1'b1);
        tick(); idle_cpu();
        tick();
        chk("idle_c_outdata", c_outdata, 8'h5A);

        // Trigger with page C1
        t0 = cyc;
        c_store = 1'b1; c_address = 16'hFF46; c_indata = 8'hC1;
        #1;
        chk("trig_no_m_store", m_store, 1'b0);
        chk("trig_c_ready", c_ready, 1'b1);
        tick(); idle_cpu(); #1;
        chk("t1_dma_active", dma_active, 1'b1);
        chk("t1_m_load", m_load, 1'b1);
        chk("t1_m_address", m_address, 16'hC100);
        tick(); tick(); #1;
        chk("t3_m_store", m_store, 1'b1);
        chk("t3_m_address", m_address, 16'hFE00);
        chk("t3_m_indata", m_indata, pat(16'hC100));
        tick(); tick();

        // HRAM store presented in phase 0 (t+5)
        c_store = 1'b1; c_address = 16'hFF80; c_indata = 8'h33;
        #1;
        chk("hram_st_p0_ready", c_ready, 1'b0);
        chk("hram_st_p0_dma_addr", m_address, 16'hC101);
        chk("hram_st_p0_no_store", m_store, 1'b0);
        tick(); #1;
        chk("hram_st_p1_ready", c_ready, 1'b1);
        chk("hram_st_p1_m_store", m_store, 1'b1);
        chk("hram_st_p1_m_address", m_address, 16'hFF80);
        chk("hram_st_p1_m_indata", m_indata, 8'h33);
        tick();
        // HRAM load presented in phase 2 (t+7)
        c_store = 1'b0; c_load = 1'b1; c_address = 16'hFF80;
        #1;
        chk("hram_ld_p2_ready", c_ready, 1'b0);
        tick(); #1;
        chk("hram_ld_p3_ready", c_ready, 1'b1);
        chk("hram_ld_p3_m_load", m_load, 1'b1);
        chk("hram_ld_p3_m_address", m_address, 16'hFF80);
        tick(); idle_cpu();
        tick();
        chk("hram_ld_data", c_outdata, 8'h33);

        // Blocked load in phase 1 (t+10)
        c_load = 1'b1; c_address = 16'hC000;
        #1;
        chk("blk_ld_ready", c_ready, 1'b1);
        chk("blk_ld_no_m_load", m_load, 1'b0);
        tick(); idle_cpu();
        tick();
        chk("blk_ld_data", c_outdata, 8'hFF);
        // Blocked store in phase 3 (t+12)
        c_store = 1'b1; c_address = 16'hC000; c_indata = 8'h77;
        #1;
        chk("blk_st_no_m_store", m_store, 1'b0);
        tick(); idle_cpu();

        while (cyc < t0 + 639) tick();
        #1;
        chk("last_m_store", m_store, 1'b1);
        chk("last_m_address", m_address, 16'hFE9F);
        chk("last_m_indata", m_indata, pat(16'hC19F));
        tick();
        chk("t640_dma_active", dma_active, 1'b1);
        tick();
        chk("t641_dma_active", dma_active, 1'b0);
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== pat(16'hC100 + 16'(i))) bad++;
        chk("oam_copy_bad_bytes", bad, 0);
        chk("oam_no_overrun", mem[16'hFEA0], pat(16'hFEA0));
        chk("blk_st_mem_unchanged", mem[16'hC000], 8'h5A);
        chk("hram_mem", mem[16'hFF80], 8'h33);

        // Register readback while idle
        c_load = 1'b1; c_address = 16'hFF46;
        #1;
        chk("reg_rd_no_m_load", m_load, 1'b0);
        chk("reg_rd_ready", c_ready, 1'b1);
        tick(); idle_cpu();
        tick();
        chk("reg_rd_data", c_outdata, 8'hC1);

        // Restart at idx=50
        t0 = cyc;
        c_store = 1'b1; c_address = 16'hFF46; c_indata = 8'hC1;
        tick(); idle_cpu();
        while (cyc < t0 + 201) tick();
        c_store = 1'b1; c_address = 16'hFF46; c_indata = 8'hD0;
        #1;
        chk("rs_idx50_m_address", m_address, 16'hC132);
        chk("rs_c_ready", c_ready, 1'b1);
        tick(); idle_cpu(); #1;
        chk("rs_m_load", m_load, 1'b1);
        chk("rs_m_address", m_address, 16'hD000);
        tick(); tick(); #1;
        chk("rs_m_store", m_store, 1'b1);
        chk("rs_store_address", m_address, 16'hFE00);
        chk("rs_store_data", m_indata, pat(16'hD000));
        tick(); tick(); #1;
        chk("rs_idx1_m_address", m_address, 16'hD001);

        // Asynchronous reset mid-DMA
        resetn = 1'b0;
        #1;
        chk("mid_rst_dma_active", dma_active, 1'b0);
        chk("mid_rst_m_load", m_load, 1'b0);
        chk("mid_rst_m_store", m_store, 1'b0);
        chk("mid_rst_c_ready", c_ready, 1'b1);
        tick();
        resetn = 1'b1;
        tick(); #1;
        chk("post_rst_dma_active", dma_active, 1'b0);
        chk("post_rst_m_load", m_load, 1'b0);
        tick(); #1;
        chk("post_rst_m_store", m_store, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
